// File: rtl/hf_tans_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : hf_tans_recoder
//  Description : Streaming Huffman-to-tANS recoder. It consumes a serial
//                Huffman bitstream (A=0, B=10, C=11, first code bit first)
//                and re-encodes every decoded symbol with a fixed 8-state
//                tANS table. For each symbol it emits the renormalisation
//                bits and their count. It also exposes the running tANS
//                state so a downstream packer can flush it.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    INIT_STATE   tANS start state (8..15), loaded on reset and stream start
//  Ports
//    PHI          in   1  clock, rising edge
//    RST          in   1  synchronous reset, active low
//    I_F          in   1  stream-start flag, high with first bit of a stream
//    i_stream     in   1  Huffman bit, sampled every edge
//    BTR          out  2  number of valid o_stream LSBs (0 = no symbol)
//    o_stream     out  3  emitted tANS bits in [BTR-1:0], upper bits zero
//    final_state  out  4  current tANS state (8..15)
// ============================================================================
module hf_tans_recoder #(
   parameter logic [3:0] INIT_STATE = 4'd8
) (
   input  logic       PHI,
   input  logic       RST,
   input  logic       I_F,
   input  logic       i_stream,
   output logic [1:0] BTR,
   output logic [2:0] o_stream,
   output logic [3:0] final_state
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      SYM_NONE = 2'd0,
      SYM_A    = 2'd1,
      SYM_B    = 2'd2,
      SYM_C    = 2'd3
   } sym_t;

   mode_t      mode;
   mode_t      mode_nxt;
   logic       prefix;
   logic       prefix_nxt;
   logic [3:0] state_nxt;
   logic [1:0] btr_nxt;
   logic [2:0] bits_nxt;

   // Effective decode context for the current edge. A stream start
   // overrides the held state and prefix so that the bit arriving with
   // I_F is treated as the first code bit of a fresh stream.
   logic       consume;
   logic       p_cur;
   logic [3:0] x_cur;
   sym_t       sym;

   // Encoder table results for the symbol completed on this edge.
   logic [1:0] enc_k;
   logic [3:0] enc_x;

   // -------------------------------------------------------------------------
   // Registered state and outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge PHI) begin
      if (!RST) begin
         mode        <= IDLE;
         prefix      <= 1'b0;
         final_state <= INIT_STATE;
         BTR         <= 2'd0;
         o_stream    <= 3'd0;
      end else begin
         mode        <= mode_nxt;
         prefix      <= prefix_nxt;
         final_state <= state_nxt;
         BTR         <= btr_nxt;
         o_stream    <= bits_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Huffman prefix decode
   // -------------------------------------------------------------------------
   always_comb begin
      consume = (mode == RUN) || I_F;
      p_cur   = I_F ? 1'b0 : prefix;
      x_cur   = I_F ? INIT_STATE : final_state;
      sym     = SYM_NONE;
      if (consume) begin
         if (!p_cur) begin
            if (!i_stream) begin
               sym = SYM_A;
            end
         end else begin
            sym = i_stream ? SYM_C : SYM_B;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Fixed tANS table, 3 symbols x 8 states.
   //   A (Ls=4): one bit out, next state = 2*(x>>1)
   //   B (Ls=2): two bits out, next state 9 / 13 for x>>2 = 2 / 3
   //   C (Ls=2): two bits out, next state 11 / 15 for x>>2 = 2 / 3
   // Out-of-range states cannot occur; the defaults fall back to
   // INIT_STATE so the state register can never leave 8..15.
   // -------------------------------------------------------------------------
   always_comb begin
      enc_k = 2'd0;
      enc_x = x_cur;
      case (sym)
         SYM_A: begin
            enc_k = 2'd1;
            case (x_cur)
               4'd8,  4'd9:  enc_x = 4'd8;
               4'd10, 4'd11: enc_x = 4'd10;
               4'd12, 4'd13: enc_x = 4'd12;
               4'd14, 4'd15: enc_x = 4'd14;
               default:      enc_x = INIT_STATE;
            endcase
         end
         SYM_B: begin
            enc_k = 2'd2;
            case (x_cur)
               4'd8,  4'd9,  4'd10, 4'd11: enc_x = 4'd9;
               4'd12, 4'd13, 4'd14, 4'd15: enc_x = 4'd13;
               default:                    enc_x = INIT_STATE;
            endcase
         end
         SYM_C: begin
            enc_k = 2'd2;
            case (x_cur)
               4'd8,  4'd9,  4'd10, 4'd11: enc_x = 4'd11;
               4'd12, 4'd13, 4'd14, 4'd15: enc_x = 4'd15;
               default:                    enc_x = INIT_STATE;
            endcase
         end
         default: begin
            enc_k = 2'd0;
            enc_x = x_cur;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Next-state and output selection
   // -------------------------------------------------------------------------
   always_comb begin
      mode_nxt   = mode;
      prefix_nxt = prefix;
      state_nxt  = final_state;
      btr_nxt    = 2'd0;
      bits_nxt   = 3'd0;

      if (consume) begin
         mode_nxt = RUN;
         if (sym == SYM_NONE) begin
            // Prefix bit of B/C taken: remember it; a restart still
            // reloads the start state even though no symbol completes.
            prefix_nxt = 1'b1;
            state_nxt  = x_cur;
         end else begin
            prefix_nxt = 1'b0;
            state_nxt  = enc_x;
            btr_nxt    = enc_k;
            // Low k bits of the pre-encode state; bit 1 only for k=2.
            bits_nxt   = {1'b0, (enc_k == 2'd2) ? x_cur[1] : 1'b0, x_cur[0]};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hf_tans_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hf_tans_recoder
//  Description : Self-checking bench for hf_tans_recoder. Directed streams
//                with fixed expected values, then randomized bits, resets
//                and restarts compared with a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hf_tans_recoder;

   logic       PHI;
   logic       RST;
   logic       I_F;
   logic       i_stream;
   logic [1:0] BTR;
   logic [2:0] o_stream;
   logic [3:0] final_state;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_run;
   bit m_p;
   int m_x;
   int m_btr;
   int m_o;

   hf_tans_recoder #(.INIT_STATE(4'd8)) dut (
      .PHI         (PHI),
      .RST         (RST),
      .I_F         (I_F),
      .i_stream    (i_stream),
      .BTR         (BTR),
      .o_stream    (o_stream),
      .final_state (final_state)
   );

   initial PHI = 1'b0;
   always #5 PHI = ~PHI;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge, written from the symbol rules.
   task automatic model_edge(input bit r, input bit f, input bit b);
      int y;
      int sym; // 0 none, 1 A, 2 B, 3 C
      if (!r) begin
         m_run = 0; m_p = 0; m_x = 8; m_btr = 0; m_o = 0;
         return;
      end
      m_btr = 0;
      m_o   = 0;
      sym   = 0;
      if (f) begin
         m_run = 1; m_p = 0; m_x = 8;
      end
      if (!m_run) return;
      if (!m_p) begin
         if (b) m_p = 1;
         else   sym = 1;
      end else begin
         sym = b ? 3 : 2;
         m_p = 0;
      end
      if (sym == 1) begin
         m_btr = 1;
         m_o   = m_x % 2;
         y     = m_x / 2;
         m_x   = 8 + 2 * (y - 4);
      end else if (sym != 0) begin
         m_btr = 2;
         m_o   = m_x % 4;
         y     = m_x / 4;
         if (sym == 2) m_x = (y == 2) ? 9 : 13;
         else          m_x = (y == 2) ? 11 : 15;
      end
   endtask

   task automatic step(input bit r, input bit f, input bit b);
      @(negedge PHI);
      RST = r; I_F = f; i_stream = b;
      @(posedge PHI);
      model_edge(r, f, b);
      #1;
      chk("btr",    int'(BTR),         m_btr);
      chk("ostream", int'(o_stream),   m_o);
      chk("fstate", int'(final_state), m_x);
      chk("range",  int'(final_state >= 4'd8), 1);
      chk("upper",  int'(o_stream) >> BTR, 0);
   endtask

   int s1_bits [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0};
   int s1_btr  [11] = '{1, 0, 2, 0, 2, 1, 1, 1, 0, 2, 1};
   int s1_o    [11] = '{0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1};
   int s1_fs   [11] = '{8, 8, 11, 11, 9, 8, 8, 8, 8, 9, 8};
   int s2_bits [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1};

   initial begin
      RST = 1'b0; I_F = 1'b0; i_stream = 1'b0;
      m_run = 0; m_p = 0; m_x = 8; m_btr = 0; m_o = 0;

      // Reset held for two edges
      step(0, 0, 0);
      step(0, 1, 1);
      chk("rst_btr", int'(BTR), 0);
      chk("rst_os",  int'(o_stream), 0);
      chk("rst_fs",  int'(final_state), 8);

      // IDLE ignores bits without I_F
      for (int i = 0; i < 4; i++) begin
         step(1, 0, i[0]);
         chk("idle_btr", int'(BTR), 0);
         chk("idle_fs",  int'(final_state), 8);
      end

      // Stream ACBAAABA
      for (int i = 0; i < 11; i++) begin
         step(1, i == 0, s1_bits[i][0]);
         chk("s1_btr", int'(BTR), s1_btr[i]);
         if (s1_btr[i] != 0) chk("s1_os", int'(o_stream), s1_o[i]);
         chk("s1_fs", int'(final_state), s1_fs[i]);
      end

      // Stream AAAAABBC twice
      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < 11; i++) begin
            step(1, (n == 0) && (i == 0), s2_bits[i][0]);
            if (n == 0 && i == 10) begin
               chk("s2_c_btr", int'(BTR), 2);
               chk("s2_c_os",  int'(o_stream), 1);
               chk("s2_c_fs",  int'(final_state), 11);
            end
         end
      end
      chk("s2_end_fs", int'(final_state), 11);

      // Restart in the middle of a prefix
      step(1, 1, 1);
      step(1, 0, 1);          // C: state 11
      step(1, 0, 1);          // prefix pending
      step(1, 1, 0);          // restart, A from state 8
      chk("rs_btr", int'(BTR), 1);
      chk("rs_os",  int'(o_stream), 0);
      chk("rs_fs",  int'(final_state), 8);

      // Reset on an edge that would complete C
      step(1, 1, 1);
      step(0, 0, 1);
      chk("rm_btr", int'(BTR), 0);
      chk("rm_fs",  int'(final_state), 8);
      step(1, 0, 0);          // would be A if still running
      chk("rm_idle_btr", int'(BTR), 0);
      chk("rm_idle_fs",  int'(final_state), 8);

      // Randomized traffic with occasional resets and restarts
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) != 0,
              $urandom_range(0, 24) == 0,
              1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
